// File: rtl/gate_sweep_sequencer_if.sv
// Handshake and result bundle between a gate sweep sequencer and whatever drives it.
// The master side owns start/func_sel and the gate-under-test output y.
interface gate_sweep_sequencer_if #(
   parameter int N_IN  = 2,
   parameter int ERR_W = 4
);
   logic             start;
   logic [1:0]       func_sel;
   logic             y;
   logic [N_IN-1:0]  x;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [N_IN-1:0]  first_fail;
   logic             fail_seen;

   modport master (
      output start, func_sel, y,
      input  x, busy, done, pass, err_cnt, first_fail, fail_seen
   );

   modport slave (
      input  start, func_sel, y,
      output x, busy, done, pass, err_cnt, first_fail, fail_seen
   );
endinterface

// File: rtl/gate_sweep_sequencer.sv
// Sweeps every input combination of a small combinational gate, waits for it to settle,
// and checks its output against a selectable golden NOR/NAND/AND/OR function.
module gate_sweep_sequencer #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 4
) (
   input logic                  clk,
   input logic                  rst,
   gate_sweep_sequencer_if.slave bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRIVE  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   // vec carries one spare MSB so the last vector is detected without ever wrapping
   localparam logic [N_IN:0]    LAST_VEC = {1'b0, {N_IN{1'b1}}};
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   logic [2:0]       state;
   logic [N_IN:0]    vec;
   logic [CNT_W-1:0] cnt;
   logic [N_IN-1:0]  x_q;
   logic             busy_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_q;
   logic [N_IN-1:0]  first_fail_q;
   logic             fail_seen_q;
   logic             exp_bit;
   logic             mismatch;

   always_comb begin
      exp_bit = 1'b0;
      case (bus.func_sel)
         2'b00:   exp_bit = ~(|x_q);
         2'b01:   exp_bit = ~(&x_q);
         2'b10:   exp_bit = &x_q;
         default: exp_bit = |x_q;
      endcase
   end

   // Case inequality so an undriven or unknown gate output is always a failure
   assign mismatch = (bus.y !== exp_bit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         vec          <= '0;
         cnt          <= '0;
         x_q          <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         first_fail_q <= '0;
         fail_seen_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  err_q        <= '0;
                  first_fail_q <= '0;
                  fail_seen_q  <= 1'b0;
                  pass_q       <= 1'b0;
                  vec          <= '0;
                  busy_q       <= 1'b1;
                  state        <= ST_DRIVE;
               end
            end

            ST_DRIVE: begin
               x_q    <= vec[N_IN-1:0];
               cnt    <= CNT_W'(SETTLE);
               busy_q <= 1'b1;
               state  <= (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end

            ST_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               if (mismatch) begin
                  if (err_q != ERR_MAX) begin
                     err_q <= err_q + ERR_W'(1);
                  end
                  if (!fail_seen_q) begin
                     first_fail_q <= x_q;
                     fail_seen_q  <= 1'b1;
                  end
               end
               if (vec == LAST_VEC) begin
                  busy_q <= 1'b0;
                  state  <= ST_DONE;
               end else begin
                  vec   <= vec + 1'b1;
                  state <= ST_DRIVE;
               end
            end

            ST_DONE: begin
               pass_q <= (err_q == '0);
               state  <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.x          = x_q;
   assign bus.busy       = busy_q;
   assign bus.done       = (state == ST_DONE);
   assign bus.pass       = pass_q;
   assign bus.err_cnt    = err_q;
   assign bus.first_fail = first_fail_q;
   assign bus.fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Directed bench for gate_sweep_sequencer: a default build, a zero-settle build and a
// narrow-counter 3-input build, each sweeping a modelled gate with hand-computed results.
module tb_gate_sweep_sequencer;

   logic clk;
   logic rst;
   logic stuck_high;

   int n_cmp;
   int n_bad;

   logic [1:0] x_trace [0:63];

   gate_sweep_sequencer_if #(.N_IN(2), .ERR_W(4)) bus ();
   gate_sweep_sequencer_if #(.N_IN(2), .ERR_W(4)) bus0 ();
   gate_sweep_sequencer_if #(.N_IN(3), .ERR_W(2)) sat_bus ();

   gate_sweep_sequencer #(.N_IN(2), .SETTLE(2), .ERR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   gate_sweep_sequencer #(.N_IN(2), .SETTLE(0), .ERR_W(4)) dut_s0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   gate_sweep_sequencer #(.N_IN(3), .SETTLE(2), .ERR_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pseudo-NMOS NOR model, optionally with its output stuck high
   always_comb begin
      bus.y  = stuck_high ? 1'b1 : ~(|bus.x);
      bus0.y = ~(|bus0.x);
   end

   task automatic sweep_main(output int done_at);
      int cyc;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      done_at = -1;
      while (cyc < 60) begin
         x_trace[cyc] = bus.x;
         if (bus.done) begin
            done_at = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.x !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL reset_x: got %b expected 00", bus.x);
      end
      n_cmp++;
      if ({bus.busy, bus.done, bus.pass, bus.fail_seen} !== 4'b0000) begin
         n_bad++;
         $display("[TB] FAIL reset_flags: got busy/done/pass/fail_seen=%b expected 0000",
                  {bus.busy, bus.done, bus.pass, bus.fail_seen});
      end
      n_cmp++;
      if (bus.err_cnt !== 4'd0 || bus.first_fail !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL reset_counts: got err_cnt=%0d first_fail=%b expected 0 and 00",
                  bus.err_cnt, bus.first_fail);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ideal_nor();
      int done_at;
      stuck_high   = 1'b0;
      bus.func_sel = 2'b00;
      sweep_main(done_at);
      n_cmp++;
      if (done_at != 17) begin
         n_bad++;
         $display("[TB] FAIL nor_done_latency: got %0d expected 17", done_at);
      end
      for (int v = 0; v < 4; v++) begin
         n_cmp++;
         if (x_trace[4*v + 3] !== 2'(v)) begin
            n_bad++;
            $display("[TB] FAIL nor_x_step%0d: got %b expected %b", v, x_trace[4*v + 3], 2'(v));
         end
      end
      n_cmp++;
      if (bus.err_cnt !== 4'd0 || bus.fail_seen !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL nor_done_state: got err_cnt=%0d fail_seen=%b busy=%b expected 0 0 0",
                  bus.err_cnt, bus.fail_seen, bus.busy);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.pass !== 1'b1 || bus.first_fail !== 2'b00 || bus.done !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL nor_pass: got pass=%b first_fail=%b done=%b expected 1 00 0",
                  bus.pass, bus.first_fail, bus.done);
      end
      n_cmp++;
      if (bus.x !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL nor_x_hold: got %b expected 11", bus.x);
      end
   endtask

   task automatic test_stuck_high();
      int done_at;
      stuck_high   = 1'b1;
      bus.func_sel = 2'b00;
      sweep_main(done_at);
      n_cmp++;
      if (done_at != 17) begin
         n_bad++;
         $display("[TB] FAIL stuck_done_latency: got %0d expected 17", done_at);
      end
      n_cmp++;
      if (bus.err_cnt !== 4'd3 || bus.first_fail !== 2'b01 || bus.fail_seen !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL stuck_result: got err_cnt=%0d first_fail=%b fail_seen=%b expected 3 01 1",
                  bus.err_cnt, bus.first_fail, bus.fail_seen);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.pass !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL stuck_pass: got %b expected 0", bus.pass);
      end
      stuck_high = 1'b0;
   endtask

   task automatic test_nand_golden();
      int done_at;
      bus.func_sel = 2'b01;
      sweep_main(done_at);
      n_cmp++;
      if (done_at != 17) begin
         n_bad++;
         $display("[TB] FAIL nand_done_latency: got %0d expected 17", done_at);
      end
      n_cmp++;
      if (bus.err_cnt !== 4'd2 || bus.first_fail !== 2'b01 || bus.fail_seen !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL nand_result: got err_cnt=%0d first_fail=%b fail_seen=%b expected 2 01 1",
                  bus.err_cnt, bus.first_fail, bus.fail_seen);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.pass !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL nand_pass: got %b expected 0", bus.pass);
      end
      bus.func_sel = 2'b00;
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      int done_pulses;
      int done_at;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (bus.x !== 2'b10 || bus.busy !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL midrst_before: got x=%b busy=%b expected 10 1", bus.x, bus.busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (bus.x !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_cnt !== 4'd0) begin
         n_bad++;
         $display("[TB] FAIL midrst_after: got x=%b busy=%b done=%b err_cnt=%0d expected 00 0 0 0",
                  bus.x, bus.busy, bus.done, bus.err_cnt);
      end
      done_pulses = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_pulses++;
      end
      n_cmp++;
      if (done_pulses != 0) begin
         n_bad++;
         $display("[TB] FAIL midrst_quiet: got %0d done/busy cycles expected 0", done_pulses);
      end
      sweep_main(done_at);
      @(negedge clk);
      n_cmp++;
      if (done_at != 17 || bus.pass !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL midrst_resweep: got done_at=%0d pass=%b expected 17 1", done_at, bus.pass);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      int first_done;
      int done_pulses;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      first_done  = -1;
      done_pulses = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         bus.start = (cyc == 6);
         if (bus.done) begin
            done_pulses++;
            if (first_done < 0) first_done = cyc;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      n_cmp++;
      if (first_done != 17 || done_pulses != 1) begin
         n_bad++;
         $display("[TB] FAIL start_ignored: got done_at=%0d pulses=%0d expected 17 1",
                  first_done, done_pulses);
      end
      n_cmp++;
      if (bus.pass !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL start_ignored_pass: got %b expected 1", bus.pass);
      end
   endtask

   task automatic test_settle_zero();
      int cyc;
      int done_at;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      done_at = -1;
      for (cyc = 1; cyc < 40; cyc++) begin
         if (bus0.done) begin
            done_at = cyc;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done_at != 9) begin
         n_bad++;
         $display("[TB] FAIL settle0_latency: got %0d expected 9", done_at);
      end
      @(negedge clk);
      n_cmp++;
      if (bus0.pass !== 1'b1 || bus0.err_cnt !== 4'd0 || bus0.x !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL settle0_result: got pass=%b err_cnt=%0d x=%b expected 1 0 11",
                  bus0.pass, bus0.err_cnt, bus0.x);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      int done_at;
      // A NAND golden makes a floating output fail whether it reads as Z or as 0
      sat_bus.func_sel = 2'b01;
      sat_bus.y        = 1'bz;
      sat_bus.start    = 1'b1;
      @(negedge clk);
      sat_bus.start = 1'b0;
      done_at = -1;
      for (cyc = 1; cyc < 80; cyc++) begin
         if (sat_bus.done) begin
            done_at = cyc;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done_at != 33) begin
         n_bad++;
         $display("[TB] FAIL sat_latency: got %0d expected 33", done_at);
      end
      n_cmp++;
      if (sat_bus.err_cnt !== 2'd3 || sat_bus.first_fail !== 3'b000 || sat_bus.fail_seen !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL sat_result: got err_cnt=%0d first_fail=%b fail_seen=%b expected 3 000 1",
                  sat_bus.err_cnt, sat_bus.first_fail, sat_bus.fail_seen);
      end
      @(negedge clk);
      n_cmp++;
      if (sat_bus.pass !== 1'b0 || sat_bus.err_cnt !== 2'd3) begin
         n_bad++;
         $display("[TB] FAIL sat_pass: got pass=%b err_cnt=%0d expected 0 3", sat_bus.pass, sat_bus.err_cnt);
      end
   endtask

   initial begin
      n_cmp            = 0;
      n_bad            = 0;
      rst              = 1'b1;
      stuck_high       = 1'b0;
      bus.start        = 1'b0;
      bus.func_sel     = 2'b00;
      bus0.start       = 1'b0;
      bus0.func_sel    = 2'b00;
      sat_bus.start    = 1'b0;
      sat_bus.func_sel = 2'b00;
      sat_bus.y        = 1'b0;
      @(negedge clk);

      test_reset();
      test_ideal_nor();
      test_stuck_high();
      test_nand_golden();
      test_reset_mid_sweep();
      test_start_ignored();
      test_settle_zero();
      test_saturation();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
